bus_select_pipe: RTL
====================

Name: bus_select_pipe

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of NSRC WIDTH-bit sources onto the processor bus using a one-hot select, with one cycle of latency.
- Adds a valid qualifier, a hold (stall) input, illegal-select detection with pulse, sticky and saturating-count reporting, and an encoded index of the driving source.
- Sits between the register file/DIN/G sources and the shared BusWires consumers.

Parameters:
- WIDTH, 16: data width of each source and of the bus.
- NSRC, 10: number of sources. Bit NSRC-1 is the highest-priority name slot (DIN in the processor map); bit 0 is the last register.
- DEFAULT_VAL, 16'h55AA: bus value driven on an illegal select. Width WIDTH.
- ERR_CNT_W, 8: width of the illegal-select counter.

Ports:
- Clock, in, 1: rising-edge clock.
- Reset, in, 1: synchronous, active-high reset.
- Src, in, NSRC*WIDTH: flattened sources. Source i occupies bits [i*WIDTH +: WIDTH].
- Select, in, NSRC: one-hot select. Bit i picks source i.
- SelValid, in, 1: Select is meaningful this cycle.
- Hold, in, 1: freeze all outputs and ignore inputs.
- ClrErr, in, 1: clear ErrSticky and ErrCount.
- BusOut, out, WIDTH: registered bus value.
- BusValid, out, 1: BusOut was loaded from a legal select on the previous accepted cycle.
- SelIdx, out, clog2(NSRC): encoded index of the source currently on BusOut.
- SelErr, out, 1: one-cycle pulse on an illegal select.
- ErrSticky, out, 1: set on any illegal select; held until ClrErr or Reset.
- ErrCount, out, ERR_CNT_W: saturating count of illegal selects.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, acts on the rising edge of Clock, and overrides every other input.
- Reset values:
  - BusOut = DEFAULT_VAL.
  - BusValid = 0, SelIdx = 0, SelErr = 0, ErrSticky = 0, ErrCount = 0.
- Latency: all outputs are registered. The response appears on the edge after the input cycle, i.e. 1-cycle latency.
- Legal select = exactly one bit of Select set.
  - Zero bits set is illegal.
  - More than one bit set is illegal.
- Priority per cycle: Reset > Hold > SelValid.
- Hold = 1:
  - BusOut, BusValid and SelIdx retain their values.
  - SelErr <= 0. No error counting, even if Select is illegal.
  - ClrErr is still honoured.
- Hold = 0, SelValid = 1, legal select i:
  - BusOut <= Src[i], SelIdx <= i, BusValid <= 1, SelErr <= 0.
- Hold = 0, SelValid = 1, illegal select:
  - BusOut <= DEFAULT_VAL, BusValid <= 0, SelErr <= 1.
  - ErrSticky <= 1.
  - ErrCount <= ErrCount + 1, saturating at all-ones (no wrap).
  - SelIdx retains its value.
- Hold = 0, SelValid = 0:
  - BusValid <= 0, SelErr <= 0.
  - BusOut and SelIdx retain their values. Select is not checked.
- ClrErr = 1 alone: ErrSticky <= 0, ErrCount <= 0.
- ClrErr = 1 in the same cycle as a counted illegal select: the clear applies first, so ErrSticky = 1 and ErrCount = 1.
- Src changing while Hold = 1 or SelValid = 0 has no effect on BusOut.
- Reset in mid-stream discards any value in flight. The next accepted cycle after Reset deasserts behaves normally.
- No combinational path from any input to any output.

Decomposition:
- Shared package bus_pkg:
  - DEFAULT_BUS_VAL = 16'h55AA.
  - clog2 function.
  - Processor source-index constants: SRC_DIN = 9, SRC_G = 8, SRC_R0 = 7 … SRC_R7 = 0.
- One combinational sub-module, onehot_decode:
  - Input: NSRC-bit vector.
  - Outputs: encoded index, plus legal flag (exactly one bit set).
  - Parametrised on NSRC; reused by future register-enable decoding.

Test Plan:
- Reset held for 2 cycles -> BusOut = 16'h55AA, BusValid = 0, SelErr = 0, ErrCount = 0, ErrSticky = 0.
- Src[7] = 16'h1234 (R0), Select = 10'b00_1000_0000, SelValid = 1 -> next cycle BusOut = 16'h1234, BusValid = 1, SelIdx = 7. Then sweep all 10 one-hot selects, each output matching with 1-cycle latency.
- Select = 10'b00_1100_0000, SelValid = 1 -> next cycle BusOut = 16'h55AA, BusValid = 0, SelErr = 1 for exactly one cycle, ErrSticky = 1, ErrCount = 1. Select = 0 then gives ErrCount = 2.
- After a legal load of 16'hBEEF, Hold = 1 for 3 cycles with an illegal Select and changing Src -> BusOut stays 16'hBEEF, BusValid stays 1, ErrCount unchanged.
- ERR_CNT_W = 2: apply 5 illegal selects -> ErrCount = 3 (saturated). ClrErr together with a 6th illegal select -> ErrCount = 1, ErrSticky = 1.
- Legal load in flight with Reset asserted the same cycle -> BusOut = 16'h55AA and BusValid = 0 on the next edge.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and helpers for the processor bus datapath.
package bus_pkg;
    localparam logic [15:0] DEFAULT_BUS_VAL = 16'h55AA;
    localparam int SRC_DIN = 9;
    localparam int SRC_G   = 8;
    localparam int SRC_R0  = 7;
    localparam int SRC_R1  = 6;
    localparam int SRC_R2  = 5;
    localparam int SRC_R3  = 4;
    localparam int SRC_R4  = 3;
    localparam int SRC_R5  = 2;
    localparam int SRC_R6  = 1;
    localparam int SRC_R7  = 0;

    // Never returns 0 so single-entry vectors still get a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/onehot_decode.sv
// onehot_decode: encodes a one-hot vector and flags whether exactly one bit is set.
module onehot_decode
    import bus_pkg::*;
#(
    parameter int NSRC = 10
) (
    input  logic [NSRC-1:0]        i_vec,
    output logic [clog2(NSRC)-1:0] o_idx,
    output logic                   o_legal
);
    localparam int IW = clog2(NSRC);

    // OR of set-bit positions; only meaningful when o_legal is high.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < NSRC; i++)
            if (i_vec[i]) o_idx = o_idx | IW'(i);
    end

    assign o_legal = (|i_vec) && !(|(i_vec & (i_vec - NSRC'(1))));
endmodule

// File: rtl/bus_select_pipe.sv
// bus_select_pipe: registered one-hot bus multiplexer with valid, hold and
// illegal-select reporting (pulse, sticky flag, saturating count).
module bus_select_pipe
    import bus_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               NSRC        = 10,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(DEFAULT_BUS_VAL),
    parameter int               ERR_CNT_W   = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NSRC*WIDTH-1:0]  i_src,
    input  logic [NSRC-1:0]        i_select,
    input  logic                   i_sel_valid,
    input  logic                   i_hold,
    input  logic                   i_clr_err,
    output logic [WIDTH-1:0]       o_bus_out,
    output logic                   o_bus_valid,
    output logic [clog2(NSRC)-1:0] o_sel_idx,
    output logic                   o_sel_err,
    output logic                   o_err_sticky,
    output logic [ERR_CNT_W-1:0]   o_err_count
);
    localparam int IW = clog2(NSRC);

    logic [WIDTH-1:0]     r_bus_out;
    logic                 r_bus_valid;
    logic [IW-1:0]        r_sel_idx;
    logic                 r_sel_err;
    logic                 r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [IW-1:0]        w_idx;
    logic                 w_legal;
    logic [ERR_CNT_W-1:0] w_cnt_base;

    onehot_decode #(.NSRC(NSRC)) u_dec (
        .i_vec   (i_select),
        .o_idx   (w_idx),
        .o_legal (w_legal)
    );

    // Clear is applied before a same-cycle illegal select is counted.
    assign w_cnt_base = i_clr_err ? '0 : r_err_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bus_out    <= DEFAULT_VAL;
            r_bus_valid  <= 1'b0;
            r_sel_idx    <= '0;
            r_sel_err    <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (i_clr_err) begin
                r_err_sticky <= 1'b0;
                r_err_count  <= '0;
            end
            if (i_hold) begin
                r_sel_err <= 1'b0;
            end else if (i_sel_valid && w_legal) begin
                r_bus_out   <= i_src[w_idx*WIDTH +: WIDTH];
                r_sel_idx   <= w_idx;
                r_bus_valid <= 1'b1;
                r_sel_err   <= 1'b0;
            end else if (i_sel_valid) begin
                r_bus_out    <= DEFAULT_VAL;
                r_bus_valid  <= 1'b0;
                r_sel_err    <= 1'b1;
                r_err_sticky <= 1'b1;
                r_err_count  <= (&w_cnt_base) ? w_cnt_base : w_cnt_base + 1'b1;
            end else begin
                r_bus_valid <= 1'b0;
                r_sel_err   <= 1'b0;
            end
        end
    end

    assign o_bus_out    = r_bus_out;
    assign o_bus_valid  = r_bus_valid;
    assign o_sel_idx    = r_sel_idx;
    assign o_sel_err    = r_sel_err;
    assign o_err_sticky = r_err_sticky;
    assign o_err_count  = r_err_count;
endmodule
